ram_burst_master: RTL

Burst initiator for the 128x32 single-port memory in the memory subsystem. Accepts read/write burst commands on a valid/ready command port and streams words on separate valid/ready write-data and read-data channels. Drives the memory's `we`/`address`/`d` inputs and samples its asynchronous-read `q` output, auto-incrementing the address per word. Sits between the datapath or test sequencer and the RAM instance, so upstream logic never handles raw memory timing.

---
 rtl/ram_burst_master_if.sv | 43 ++++
 rtl/ram_burst_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram_burst_master_if.sv
// Command, write-data, read-data and RAM-port bundle for ram_burst_master.
interface ram_burst_master_if #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [Addr_width-1:0] cmd_addr;
    logic [Addr_width-1:0] cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [Data_width-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [Data_width-1:0] rd_data;
    logic                  mem_we;
    logic [Addr_width-1:0] mem_addr;
    logic [Data_width-1:0] mem_d;
    logic [Data_width-1:0] mem_q;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output mem_we, mem_addr, mem_d,
        input  mem_q
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  mem_we, mem_addr, mem_d,
        output mem_q
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst read/write initiator for a single-port async-read RAM.
// Optional XOR burst checksum on chk when RAM_BURST_CHECKSUM_EN is defined.
module ram_burst_master #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_burst_master_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic [Data_width-1:0] chk
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [Addr_width-1:0] One = Addr_width'(1);

    state_t                state, state_nxt;
    logic [Addr_width-1:0] addr_r, addr_nxt;
    logic [Addr_width-1:0] cnt_r, cnt_nxt;
    logic                  rd_valid_r, rd_valid_nxt;
    logic [Data_width-1:0] rd_data_r, rd_data_nxt;
    logic                  done_r, done_nxt;
    logic                  capture;

    assign capture = (state == READ) && (!rd_valid_r || bus.rd_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_r     <= '0;
            cnt_r      <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_r     <= addr_nxt;
            cnt_r      <= cnt_nxt;
            rd_valid_r <= rd_valid_nxt;
            rd_data_r  <= rd_data_nxt;
            done_r     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_r;
        cnt_nxt       = cnt_r;
        rd_valid_nxt  = rd_valid_r;
        rd_data_nxt   = rd_data_r;
        done_nxt      = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_d     = '0;
        bus.mem_addr  = addr_r;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_nxt  = bus.cmd_addr;
                    cnt_nxt   = bus.cmd_len;
                    state_nxt = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                // A beat in the reset cycle must not reach the RAM
                bus.mem_we   = bus.wr_valid && !reset;
                bus.mem_d    = bus.wr_data;
                if (bus.wr_valid) begin
                    addr_nxt = addr_r + One;
                    cnt_nxt  = cnt_r - One;
                    if (cnt_r == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            READ: begin
                if (capture) begin
                    rd_data_nxt  = bus.mem_q;
                    rd_valid_nxt = 1'b1;
                    addr_nxt     = addr_r + One;
                    cnt_nxt      = cnt_r - One;
                    if (cnt_r == '0) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.rd_ready) begin
                    rd_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                    done_nxt     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign busy         = (state != IDLE);
    assign done         = done_r;

`ifdef RAM_BURST_CHECKSUM_EN
    logic [Data_width-1:0] chk_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_r <= '0;
        end else if (state == IDLE && bus.cmd_valid) begin
            chk_r <= '0;
        end else if (state == WRITE && bus.wr_valid) begin
            chk_r <= chk_r ^ bus.wr_data;
        end else if (capture) begin
            chk_r <= chk_r ^ bus.mem_q;
        end
    end

    assign chk = chk_r;
`else
    assign chk = '0;
`endif
endmodule
